dtc_rx_param: RTL and testbench
===============================

Name: dtc_rx_param

Overview:
Parametrised DTC link receiver. It decodes two pre-sampled serial streams from the SRU link: the trigger bit (rising-edge IDDR output) and the command bit (falling-edge IDDR output). The trigger stream yields L0/L1 pulses with a configurable hold-off. The command stream carries fast commands from a configurable code table and slow read/write frames of configurable address/data width, protected by a parity bit. It sits directly behind the IDDR primitives in the FEC control path; the IDDRs stay outside this block.

Parameters:
HDR_W, 8, header/command code width in bits
ADDR_W, 32, slow-frame address field width; address MSB is the read/write flag
DATA_W, 32, slow-frame data field width
SLOW_CODE, 8'hE1, header that opens a slow frame (HDR_W bits)
N_FAST, 6, number of fast command codes
FAST_CODES, {8'hEF,8'hE9,8'hE8,8'hEA,8'hE4,8'hE2}, packed N_FAST*HDR_W table; entry i drives fast_cmd[i]
TRIG_HOLDOFF, 0, extra cycles trig_bit is ignored after an L0/L1 pulse
CNT_W, 16, width of the saturating status counters

Ports:
dtc_clk_90  in  1  link clock; all logic on its rising edge
rst  in  1  synchronous, active-low reset
trig_bit  in  1  trigger stream sample (IDDR Q1)
cmd_bit  in  1  command stream sample (IDDR Q2)
trig_l0  out  1  one-cycle L0 pulse
trig_l1  out  1  one-cycle L1 pulse
fast_cmd  out  N_FAST  one-hot, one-cycle fast command pulses
address  out  ADDR_W  address of last good slow frame
data  out  DATA_W  data of last good slow frame
write  out  1  one-cycle pulse: good frame with address MSB = 0
read  out  1  one-cycle pulse: good frame with address MSB = 1
parity_err  out  1  one-cycle pulse: slow frame failed parity
frame_cnt  out  CNT_W  good slow frames, saturating
err_cnt  out  CNT_W  parity-failed slow frames, saturating

Behaviour:
- Reset (rst=0 at an edge): all outputs 0; both FSMs go to their idle states; header shift register, bit counter and hold-off counter cleared. Reset takes effect mid-frame or mid-trigger; partial data is discarded.
- Trigger FSM states: IDLE, ARM, PULSE, HOLD.
  - IDLE: trig_bit=1 -> ARM.
  - ARM: trig_bit=1 -> PULSE with trig_l1=1; trig_bit=0 -> PULSE with trig_l0=1. The pulse is registered, high in the cycle after the second bit.
  - PULSE: lasts one cycle; trig_bit is ignored. Goes to HOLD if TRIG_HOLDOFF>0, else to IDLE.
  - HOLD: ignores trig_bit for TRIG_HOLDOFF cycles, then goes to IDLE.
  - trig_l0 and trig_l1 are never high together.
- Command FSM states: HUNT, PAYLOAD.
  - HUNT: cmd_bit shifts into the HDR_W-bit header register, MSB first.
  - Matching uses the next value {hdr[HDR_W-2:0], cmd_bit}. If it equals SLOW_CODE: go to PAYLOAD, bit counter = ADDR_W+DATA_W+1. If it equals FAST_CODES[i]: fast_cmd[i]=1 for one cycle, starting the cycle after the last header bit.
  - After any match the header register clears to 0, so overlapping codes are not re-detected.
  - SLOW_CODE has priority over the fast table. Duplicate table entries assert every matching bit.
- PAYLOAD:
  - Serial order is address MSB first, then data MSB first, then one parity bit. The parity bit makes the total count of ones over address, data and parity even.
  - Bits shift into an ADDR_W+DATA_W+1 staging register. The header register is frozen and no fast commands are decoded.
  - On the edge that takes the parity bit (counter reaches 0), with good parity: address and data load; write or read pulses per the address MSB in the next cycle; frame_cnt increments.
  - With bad parity: parity_err pulses; err_cnt increments; address and data hold their old values.
  - After the parity bit, return to HUNT with the header cleared.
- address and data keep their values until the next good frame.
- Counters saturate at all-ones; no wrap-around.
- The trigger and command paths are independent; simultaneous events on both are all reported.

Test Plan:
1. Reset, then cmd_bit serial 8'hE4 -> fast_cmd=6'b000010 for exactly one cycle, one cycle after the last bit; no other outputs toggle.
2. Slow frame E1, address 32'h0000_1234, data 32'hDEAD_BEEF, parity 1 -> write=1 for one cycle; address=32'h0000_1234; data=32'hDEAD_BEEF; frame_cnt=1.
3. Same frame with parity 0 -> parity_err pulse; err_cnt=1; address/data unchanged; write and read stay 0.
4. Slow frame with address 32'h8000_0010 whose payload contains the pattern E2 -> read pulse only; no fast_cmd during the payload.
5. trig_bit 1,1 -> trig_l1 pulse. Then 1,0 after idle -> trig_l0 pulse. With TRIG_HOLDOFF=3, a 1 within 4 cycles after a pulse -> ignored.
6. Reset asserted mid-payload, released, then E8 sent -> no write/read; fast_cmd[3] pulses; counters read 0.

Source files
------------

// File: rtl/dtc_rx_param.sv
// DTC link receiver: decodes the trigger stream into L0/L1 pulses and the
// command stream into fast commands and parity-checked slow read/write frames.
module dtc_rx_param #(
  parameter int                       HDR_W        = 8,
  parameter int                       ADDR_W       = 32,
  parameter int                       DATA_W       = 32,
  parameter logic [HDR_W-1:0]         SLOW_CODE    = 8'hE1,
  parameter int                       N_FAST       = 6,
  parameter logic [N_FAST*HDR_W-1:0]  FAST_CODES   = {8'hEF, 8'hE9, 8'hE8, 8'hEA, 8'hE4, 8'hE2},
  parameter int                       TRIG_HOLDOFF = 0,
  parameter int                       CNT_W        = 16
) (
  input  logic              dtc_clk_90,
  input  logic              rst,
  input  logic              trig_bit,
  input  logic              cmd_bit,
  output logic              trig_l0,
  output logic              trig_l1,
  output logic [N_FAST-1:0] fast_cmd,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              write,
  output logic              read,
  output logic              parity_err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int FRAME_W = ADDR_W + DATA_W + 1;
  localparam int BCNT_W  = $clog2(FRAME_W + 1);
  localparam int HOLD_W  = (TRIG_HOLDOFF > 1) ? $clog2(TRIG_HOLDOFF) : 1;

  // ---------------- trigger path ----------------
  typedef enum logic [1:0] {T_IDLE, T_ARM, T_PULSE, T_HOLD} trig_state_t;

  trig_state_t       t_state, t_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic              l0_n, l1_n;

  always_comb begin
    t_next = t_state;
    l0_n   = 1'b0;
    l1_n   = 1'b0;
    case (t_state)
      T_IDLE:  if (trig_bit) t_next = T_ARM;
      T_ARM: begin
        t_next = T_PULSE;
        l1_n   = trig_bit;
        l0_n   = ~trig_bit;
      end
      T_PULSE: t_next = (TRIG_HOLDOFF > 0) ? T_HOLD : T_IDLE;
      T_HOLD:  if (hold_cnt == '0) t_next = T_IDLE;
      default: t_next = T_IDLE;
    endcase
  end

  always_ff @(posedge dtc_clk_90) begin
    if (!rst) begin
      t_state  <= T_IDLE;
      hold_cnt <= '0;
      trig_l0  <= 1'b0;
      trig_l1  <= 1'b0;
    end else begin
      t_state <= t_next;
      trig_l0 <= l0_n;
      trig_l1 <= l1_n;
      if (t_state == T_PULSE)
        hold_cnt <= HOLD_W'(TRIG_HOLDOFF - 1);
      else if (t_state == T_HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // ---------------- command path ----------------
  typedef enum logic {C_HUNT, C_PAYLOAD} cmd_state_t;

  cmd_state_t         c_state, c_next;
  logic [HDR_W-1:0]   hdr, hdr_next;
  logic [BCNT_W-1:0]  bcnt;
  logic [FRAME_W-1:0] stage, stage_next;
  logic               slow_hit, last_bit, good;
  logic [N_FAST-1:0]  fast_hit, fast_n;
  logic               wr_n, rd_n, perr_n;

  assign hdr_next   = {hdr[HDR_W-2:0], cmd_bit};
  assign stage_next = {stage[FRAME_W-2:0], cmd_bit};
  assign slow_hit   = (hdr_next == SLOW_CODE);
  assign last_bit   = (c_state == C_PAYLOAD) && (bcnt == BCNT_W'(1));
  assign good       = ~(^stage_next);

  always_comb begin
    for (int unsigned i = 0; i < N_FAST; i++)
      fast_hit[i] = (hdr_next == FAST_CODES[i*HDR_W +: HDR_W]);
  end

  always_comb begin
    c_next = c_state;
    fast_n = '0;
    wr_n   = 1'b0;
    rd_n   = 1'b0;
    perr_n = 1'b0;
    case (c_state)
      C_HUNT: begin
        if (slow_hit)
          c_next = C_PAYLOAD;
        else
          fast_n = fast_hit;
      end
      C_PAYLOAD: begin
        if (last_bit) begin
          c_next = C_HUNT;
          if (good) begin
            wr_n = ~stage_next[FRAME_W-1];
            rd_n = stage_next[FRAME_W-1];
          end else begin
            perr_n = 1'b1;
          end
        end
      end
      default: c_next = C_HUNT;
    endcase
  end

  // hdr is cleared on every match and stays frozen (at zero) through the payload
  always_ff @(posedge dtc_clk_90) begin
    if (!rst) begin
      c_state    <= C_HUNT;
      hdr        <= '0;
      bcnt       <= '0;
      stage      <= '0;
      fast_cmd   <= '0;
      write      <= 1'b0;
      read       <= 1'b0;
      parity_err <= 1'b0;
      address    <= '0;
      data       <= '0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      c_state    <= c_next;
      fast_cmd   <= fast_n;
      write      <= wr_n;
      read       <= rd_n;
      parity_err <= perr_n;
      if (c_state == C_HUNT) begin
        hdr <= (slow_hit || (|fast_hit)) ? '0 : hdr_next;
        if (slow_hit)
          bcnt <= BCNT_W'(FRAME_W);
      end else begin
        bcnt  <= bcnt - 1'b1;
        stage <= stage_next;
      end
      if (wr_n || rd_n) begin
        address <= stage_next[FRAME_W-1 -: ADDR_W];
        data    <= stage_next[DATA_W:1];
        if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
      end
      if (perr_n && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dtc_rx_param.sv
// Scoreboard bench for dtc_rx_param: message-level stimulus predicts events,
// a monitor matches every output pulse against the expected queues.
module tb_dtc_rx_param;

  localparam int HOLD = 3;

  logic        clk = 1'b0;
  logic        rst, trig_bit, cmd_bit;
  logic        trig_l0, trig_l1, write, read, parity_err;
  logic [5:0]  fast_cmd;
  logic [31:0] address, data;
  logic [15:0] frame_cnt, err_cnt;

  dtc_rx_param #(.TRIG_HOLDOFF(HOLD)) dut (
    .dtc_clk_90(clk), .rst(rst), .trig_bit(trig_bit), .cmd_bit(cmd_bit),
    .trig_l0(trig_l0), .trig_l1(trig_l1), .fast_cmd(fast_cmd),
    .address(address), .data(data), .write(write), .read(read),
    .parity_err(parity_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int stamp; logic l0, l1; } tev_t;
  typedef struct {
    int stamp; logic [5:0] fast; logic wr, rd, perr;
    logic [31:0] a, d; logic [15:0] fc, ec;
  } cev_t;

  tev_t tq[$];
  cev_t cq[$];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference state
  logic [7:0]  fcode [6] = '{8'hE2, 8'hE4, 8'hEA, 8'hE8, 8'hE9, 8'hEF};
  logic        tarm = 1'b0;
  int          tblk = 0;
  logic [31:0] m_addr = '0, m_data = '0;
  logic [15:0] m_fc = '0, m_ec = '0;
  bit          trig_rand = 0;

  function automatic logic rt();
    return trig_rand ? logic'($urandom_range(0, 2) == 0) : 1'b0;
  endfunction

  // one link cycle; trigger model: after an arming 1, the next bit picks L1/L0,
  // then the pulse cycle plus HOLD cycles ignore the stream
  task automatic step(input logic t, input logic c);
    @(negedge clk);
    trig_bit = t;
    cmd_bit  = c;
    if (tblk > 0) tblk--;
    else if (tarm) begin
      tq.push_back('{stamp: cyc + 1, l0: ~t, l1: t});
      tarm = 1'b0;
      tblk = 1 + HOLD;
    end else if (t) tarm = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(rt(), 1'b0);
  endtask

  task automatic push_cmd(input logic [5:0] f, input logic w, input logic r, input logic p);
    cq.push_back('{stamp: cyc + 1, fast: f, wr: w, rd: r, perr: p,
                   a: m_addr, d: m_data, fc: m_fc, ec: m_ec});
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) step(rt(), b[i]);
  endtask

  task automatic send_fast(input int idx);
    logic [7:0] b;
    b = fcode[idx];
    for (int i = 7; i >= 1; i--) step(rt(), b[i]);
    step(rt(), b[0]);
    push_cmd(6'(1 << idx), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_slow(input logic [31:0] a, input logic [31:0] d, input bit ok);
    logic [63:0] pl;
    logic        p;
    pl = {a, d};
    p  = ^pl;
    if (!ok) p = ~p;
    send_byte(8'hE1);
    for (int i = 63; i >= 0; i--) step(rt(), pl[i]);
    step(rt(), p);
    if (ok) begin
      m_addr = a;
      m_data = d;
      if (m_fc != 16'hFFFF) m_fc++;
      push_cmd(6'd0, ~a[31], a[31], 1'b0);
    end else begin
      if (m_ec != 16'hFFFF) m_ec++;
      push_cmd(6'd0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  // monitor
  initial forever begin
    @(posedge clk);
    #1;
    if (trig_l0 && trig_l1) chk("l0_l1_exclusive", 2'b11, 2'b00);
    if (trig_l0 || trig_l1) begin
      if (tq.size() == 0) chk("unexpected_trig", {trig_l0, trig_l1}, 2'b00);
      else begin
        tev_t e;
        e = tq.pop_front();
        chk("trig_cycle", 64'(cyc), 64'(e.stamp));
        chk("trig_l0_l1", {trig_l0, trig_l1}, {e.l0, e.l1});
      end
    end else if (tq.size() != 0 && tq[0].stamp < cyc) begin
      chk("missing_trig", 64'(cyc), 64'(tq[0].stamp));
      void'(tq.pop_front());
    end
    if ((|fast_cmd) || write || read || parity_err) begin
      if (cq.size() == 0)
        chk("unexpected_cmd", {fast_cmd, write, read, parity_err}, 9'd0);
      else begin
        cev_t e;
        e = cq.pop_front();
        chk("cmd_cycle", 64'(cyc), 64'(e.stamp));
        chk("cmd_pulses", {fast_cmd, write, read, parity_err}, {e.fast, e.wr, e.rd, e.perr});
        chk("addr_data", {address, data}, {e.a, e.d});
        chk("counters", {frame_cnt, err_cnt}, {e.fc, e.ec});
      end
    end else if (cq.size() != 0 && cq[0].stamp < cyc) begin
      chk("missing_cmd", 64'(cyc), 64'(cq[0].stamp));
      void'(cq.pop_front());
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; trig_bit = 1'b0; cmd_bit = 1'b0;
    tarm = 1'b0; tblk = 0;
    m_addr = '0; m_data = '0; m_fc = '0; m_ec = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("reset_pulses", {trig_l0, trig_l1, fast_cmd, write, read, parity_err}, 11'd0);
    chk("reset_addr_data", {address, data}, 64'd0);
    chk("reset_counters", {frame_cnt, err_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; trig_bit = 1'b0; cmd_bit = 1'b0;
    do_reset();
    idle(3);

    // directed command traffic
    send_fast(1);                                   // E4
    idle(4);
    send_slow(32'h0000_1234, 32'hDEAD_BEEF, 1);
    idle(2);
    send_slow(32'h0000_1234, 32'hDEAD_BEEF, 0);
    idle(2);
    send_slow(32'h8000_0010, 32'h00E2_E200, 1);     // payload holds E2 patterns
    idle(3);

    // directed triggers: L1, L0, then a 1 inside the hold-off window
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    idle(8);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b1 & 1'b0);
    idle(8);

    // randomized mix on both paths
    trig_rand = 1;
    repeat (40) begin
      case ($urandom_range(0, 3))
        0: send_fast(int'($urandom_range(0, 5)));
        1: send_slow($urandom, $urandom, 1);
        2: send_slow($urandom, $urandom, 0);
        default: idle(int'($urandom_range(0, 5)));
      endcase
      idle(int'($urandom_range(0, 3)));
    end
    trig_rand = 0;
    idle(10);

    // reset in the middle of a payload, then a fast command
    send_slow(32'h0000_0042, 32'h1111_2222, 1);
    idle(2);
    send_byte(8'hE1);
    for (int i = 0; i < 20; i++) step(1'b0, logic'($urandom_range(0, 1)));
    do_reset();
    idle(2);
    send_fast(3);                                   // E8
    idle(10);

    chk("trig_queue_drained", 64'(tq.size()), 64'd0);
    chk("cmd_queue_drained", 64'(cq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
